// File: rtl/hilo_muldiv.sv
// ============================================================================
// Module   : hilo_muldiv
// Brief    : Iterative multiply/divide unit owning the MIPS HI/LO registers.
//            Handles MULT, MULTU, DIV, DIVU (W+2 cycle latency) and MTHI/MTLO
//            (single-cycle write). One shared W-step shift datapath.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hilo_muldiv #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_div_zero,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  localparam int            c_CW     = $clog2(W);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(W - 1);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_PREP = 2'd1;
  localparam logic [1:0] c_S_ITER = 2'd2;
  localparam logic [1:0] c_S_FIX  = 2'd3;

  localparam logic [2:0] c_OP_DIVU = 3'd3;
  localparam logic [2:0] c_OP_MTHI = 3'd4;
  localparam logic [2:0] c_OP_MTLO = 3'd5;

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [c_CW-1:0] r_count;
  logic [2:0]      r_op;
  logic [W-1:0]    r_x;      // multiplicand / divisor (magnitude after PREP)
  logic [W-1:0]    r_y;      // multiplier / dividend, shifts out; quotient shifts in
  logic            r_sa;
  logic            r_sb;
  logic [2*W-1:0]  r_acc;    // product accumulator
  logic [W-1:0]    r_rem;    // partial remainder (top bit of W+1 is implicit)
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_done;
  logic            r_dz;

  logic            w_busy;
  logic            w_is_div;
  logic            w_neg;
  logic            w_b_zero;
  logic [W:0]      w_sum;
  logic [W:0]      w_shl;
  logic [W:0]      w_diff;
  logic [2*W-1:0]  w_prod;
  logic [W-1:0]    w_fix_hi;
  logic [W-1:0]    w_fix_lo;

  // Shared datapath: shift-add for multiply, restoring subtract for divide
  assign w_is_div = r_op[1];
  assign w_neg    = r_sa ^ r_sb;
  assign w_b_zero = (r_x == '0);
  assign w_sum    = {1'b0, r_acc[2*W-1:W]} + (r_y[0] ? {1'b0, r_x} : {(W+1){1'b0}});
  assign w_shl    = {r_rem, r_y[W-1]};
  assign w_diff   = w_shl - {1'b0, r_x};
  assign w_prod   = w_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_fix_lo = w_is_div ? (w_neg ? (~r_y + 1'b1) : r_y) : w_prod[W-1:0];
  assign w_fix_hi = w_is_div ? (r_sa ? (~r_rem + 1'b1) : r_rem) : w_prod[2*W-1:W];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_S_IDLE: if (i_start && (i_op <= c_OP_DIVU)) w_next = c_S_PREP;
      c_S_PREP: w_next = c_S_ITER;
      c_S_ITER: if (r_count == c_LAST) w_next = c_S_FIX;
      c_S_FIX:  w_next = c_S_IDLE;
      default:  w_next = c_S_IDLE;
    endcase
  end

  // Busy covers every non-idle state, FIX included
  always_comb begin
    w_busy = (r_state != c_S_IDLE);
  end

  // Operand latch, iteration datapath, HI/LO and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_op    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_acc   <= '0;
      r_rem   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_S_IDLE: begin
          if (i_start) begin
            if (i_op <= c_OP_DIVU) begin
              r_op <= i_op;
              r_x  <= i_b;
              r_y  <= i_a;
              // op[0]=0 marks the signed variants
              r_sa <= ~i_op[0] & i_a[W-1];
              r_sb <= ~i_op[0] & i_b[W-1];
            end else if (i_op == c_OP_MTHI) begin
              r_hi   <= i_a;
              r_done <= 1'b1;
              r_dz   <= 1'b0;
            end else if (i_op == c_OP_MTLO) begin
              r_lo   <= i_a;
              r_done <= 1'b1;
              r_dz   <= 1'b0;
            end
          end
        end
        c_S_PREP: begin
          r_x     <= r_sb ? (~r_x + 1'b1) : r_x;
          r_y     <= r_sa ? (~r_y + 1'b1) : r_y;
          r_acc   <= '0;
          r_rem   <= '0;
          r_count <= '0;
        end
        c_S_ITER: begin
          if (w_is_div) begin
            // A set top bit of the difference means the trial subtract underflowed
            r_rem <= w_diff[W] ? w_shl[W-1:0] : w_diff[W-1:0];
            r_y   <= {r_y[W-2:0], ~w_diff[W]};
          end else begin
            r_acc <= {w_sum, r_acc[W-1:1]};
            r_y   <= {1'b0, r_y[W-1:1]};
          end
          r_count <= r_count + 1'b1;
        end
        c_S_FIX: begin
          r_done <= 1'b1;
          r_dz   <= w_is_div & w_b_zero;
          // Divide by zero leaves HI/LO untouched
          if (!(w_is_div && w_b_zero)) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = w_busy;
  assign o_done     = r_done;
  assign o_div_zero = r_dz;
  assign o_hi       = r_hi;
  assign o_lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_hilo_muldiv.sv
// ============================================================================
// Module   : tb_hilo_muldiv
// Brief    : Self-checking bench for hilo_muldiv: directed cases with literal
//            expectations plus randomized traffic against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hilo_muldiv;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  hilo_muldiv #(.W(W)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_div_zero(div_zero), .o_hi(hi), .o_lo(lo)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of an arithmetic op: {div_zero, hi, lo}
  function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic [63:0] up;
    int q, r;
    logic [31:0] rh, rl;
    rh = '0; rl = '0;
    case (o)
      3'd0: begin sp = 64'($signed(x)) * 64'($signed(y)); rh = sp[63:32]; rl = sp[31:0]; end
      3'd1: begin up = {32'd0, x} * {32'd0, y}; rh = up[63:32]; rl = up[31:0]; end
      3'd2: begin
        if (y == 0) return {1'b1, 64'd0};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = x; rh = 0; end
        else begin q = $signed(x) / $signed(y); r = $signed(x) % $signed(y); rl = q; rh = r; end
      end
      default: begin
        if (y == 0) return {1'b1, 64'd0};
        rl = x / y; rh = x % y;
      end
    endcase
    return {1'b0, rh, rl};
  endfunction

  // Reference model: countdown of W+2 cycles, result applied at expiry
  logic [W-1:0] m_hi, m_lo;
  logic         m_busy, m_done, m_dz;
  logic [64:0]  m_pend;
  int           m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
      m_cnt <= 0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_dz   <= m_pend[64];
          if (!m_pend[64]) begin m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0]; end
        end
      end else if (start) begin
        if (op <= 3'd3) begin
          m_pend <= model_op(op, a, b);
          m_cnt  <= W + 2;
          m_busy <= 1'b1;
        end else if (op == 3'd4) begin
          m_hi <= a; m_done <= 1'b1; m_dz <= 1'b0;
        end else if (op == 3'd5) begin
          m_lo <= a; m_done <= 1'b1; m_dz <= 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("div_zero", div_zero, m_dz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz, input int inj);
    int lat;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == inj) begin start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; end
      else if (start) start = 1'b0;
    end
    chk("latency", 64'(lat), (o <= 3'd3) ? 64'd34 : 64'd0);
    chk("lit_hi", hi, eh);
    chk("lit_lo", lo, el);
    chk("lit_dz", div_zero, edz);
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom % 5)
      0: return 32'd0;
      1: return $urandom % 16;
      2: return (($urandom % 2) == 0) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      3: return 32'hFFFF_FFF0 | ($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
    run_op(3'd3, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 0);
    run_op(3'd4, 32'hAAAA_0000, 32'h0, 32'hAAAA_0000, 32'h8000_0000, 1'b0, 0);
    run_op(3'd5, 32'h0000_BBBB, 32'h0, 32'hAAAA_0000, 32'h0000_BBBB, 1'b0, 0);
    run_op(3'd3, 32'h0000_0005, 32'h0, 32'hAAAA_0000, 32'h0000_BBBB, 1'b1, 0);
    run_op(3'd4, 32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0000_BBBB, 1'b0, 0);
    run_op(3'd1, 32'h0001_0000, 32'h0000_0030, 32'h0000_0000, 32'h0030_0000, 1'b0, 4);

    // Abort a divide part-way through with an asynchronous reset
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 0);

    // Randomized traffic, including starts while busy and rare resets
    repeat (4000) begin
      @(posedge clk); #1;
      start = (($urandom % 3) == 0);
      op    = 3'($urandom % 8);
      a     = rnd();
      b     = rnd();
      rst   = (($urandom % 700) == 0);
    end
    @(posedge clk); #1;
    start = 1'b0;
    rst   = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
